quad_axis_position: RTL and testbench



---
 rtl/quad_axis_pkg.sv | 12 +
 rtl/fine_pos_accum.sv | 47 ++++
 rtl/quad_axis_position.sv | 70 +++++++
 tb/tb_quad_axis_position.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/quad_axis_pkg.sv
// quad_axis_pkg: shared FSM state type and screen geometry for the per-axis cursor stages.
package quad_axis_pkg;

    typedef enum logic [1:0] {PRIME, IDLE, PEND} state_e;

    localparam int X_MAX_POS  = 639;
    localparam int Y_MAX_POS  = 479;
    localparam int X_HOME     = 320;
    localparam int Y_HOME     = 240;
    localparam int STEP_SHIFT = 2;

endpackage

// File: rtl/fine_pos_accum.sv
// fine_pos_accum: wrap-safe signed count delta into a saturating sub-pixel accumulator.
module fine_pos_accum
    import quad_axis_pkg::*;
#(
    parameter int COUNT_W    = 8,
    parameter int POS_W      = 10,
    parameter int MAX_POS    = X_MAX_POS,
    parameter int HOME_POS   = X_HOME,
    parameter int STEP_SHIFT = quad_axis_pkg::STEP_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] count,
    input  logic               clear,
    input  logic               prime,
    output logic [POS_W-1:0]   pos
);

    localparam int FW = POS_W + STEP_SHIFT;
    localparam logic [FW-1:0] FINE_MAX  = FW'((MAX_POS << STEP_SHIFT) + (1 << STEP_SHIFT) - 1);
    localparam logic [FW-1:0] FINE_HOME = FW'(HOME_POS << STEP_SHIFT);

    logic [FW-1:0]      fine_q, fine_d, clamped;
    logic [COUNT_W-1:0] count_q, delta;
    logic [FW:0]        sum;

    // One extra bit makes the sum signed-safe, so a negative result is simply the top bit.
    always_comb begin
        delta   = count - count_q;
        sum     = {1'b0, fine_q} + {{(FW + 1 - COUNT_W){delta[COUNT_W-1]}}, delta};
        clamped = sum[FW] ? '0 : (sum[FW-1:0] > FINE_MAX ? FINE_MAX : sum[FW-1:0]);
        fine_d  = clear ? FINE_HOME : (prime ? fine_q : clamped);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_q  <= FINE_HOME;
            count_q <= '0;
        end else begin
            fine_q  <= fine_d;
            count_q <= count;
        end
    end

    assign pos = fine_q[FW-1:STEP_SHIFT];

endmodule

// File: rtl/quad_axis_position.sv
// quad_axis_position: decoder count to clamped screen coordinate with a coalescing move handshake.
module quad_axis_position
    import quad_axis_pkg::*;
#(
    parameter int COUNT_W    = 8,
    parameter int POS_W      = 10,
    parameter int MAX_POS    = X_MAX_POS,
    parameter int HOME_POS   = X_HOME,
    parameter int STEP_SHIFT = quad_axis_pkg::STEP_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] count,
    input  logic               clear,
    output logic [POS_W-1:0]   pos,
    output logic               at_min,
    output logic               at_max,
    output logic               move_valid,
    output logic [POS_W-1:0]   move_pos,
    input  logic               move_ready
);

    state_e           state_q;
    logic             move_valid_q;
    logic [POS_W-1:0] move_pos_q;

    fine_pos_accum #(
        .COUNT_W   (COUNT_W),
        .POS_W     (POS_W),
        .MAX_POS   (MAX_POS),
        .HOME_POS  (HOME_POS),
        .STEP_SHIFT(STEP_SHIFT)
    ) u_accum (
        .clk  (clk),
        .rst_n(rst_n),
        .count(count),
        .clear(clear),
        .prime(state_q == PRIME),
        .pos  (pos)
    );

    // IDLE samples only the newest pos, which is what coalesces moves made under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PRIME;
            move_valid_q <= 1'b0;
            move_pos_q   <= POS_W'(HOME_POS);
        end else begin
            case (state_q)
                PRIME: state_q <= IDLE;
                IDLE: if (pos != move_pos_q) begin
                    move_pos_q   <= pos;
                    move_valid_q <= 1'b1;
                    state_q      <= PEND;
                end
                PEND: if (move_ready) begin
                    move_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign at_min     = pos == '0;
    assign at_max     = pos == POS_W'(MAX_POS);
    assign move_valid = move_valid_q;
    assign move_pos   = move_pos_q;

endmodule

// File: tb/tb_quad_axis_position.sv
// tb_quad_axis_position: directed vectors with a scoreboard monitor on accepted move requests.
module tb_quad_axis_position;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] count = 8'h00;
    logic       clear = 1'b0;
    logic       move_ready = 1'b1;
    logic [9:0] pos, move_pos;
    logic       at_min, at_max, move_valid;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    quad_axis_position dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .clear     (clear),
        .pos       (pos),
        .at_min    (at_min),
        .at_max    (at_max),
        .move_valid(move_valid),
        .move_pos  (move_pos),
        .move_ready(move_ready)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] c, input logic rdy);
        rst_n = 1'b0;
        count = c;
        move_ready = rdy;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Monitor: every accepted handshake must match the next expected coordinate.
    always @(negedge clk) begin
        if (rst_n && move_valid && move_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_move: got move_pos=%0d expected no request", move_pos);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (move_pos !== e) begin
                    failures++;
                    $display("FAIL move_pos: got %0d expected %0d", move_pos, e);
                end
            end
        end
    end

    initial begin
        // Prime: nonzero count at release must not move the cursor
        do_reset(8'h80, 1'b1);
        chk("prime_pos", 32'(pos), 320);
        chk("prime_at_min", 32'(at_min), 0);
        chk("prime_at_max", 32'(at_max), 0);
        step(3);
        chk("prime_no_valid", 32'(move_valid), 0);
        chk("prime_pos_hold", 32'(pos), 320);

        // Detent stepping
        do_reset(8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            count = 8'(i);
            step(1);
            if (i == 3) chk("detent_pos_3", 32'(pos), 320);
        end
        chk("detent_pos_4", 32'(pos), 321);
        exp_q.push_back(10'd321);
        step(1);
        chk("detent_valid", 32'(move_valid), 1);
        step(3);

        // Wrap in both directions
        do_reset(8'hFE, 1'b1);
        count = 8'h02;
        step(1);
        chk("wrap_up_pos", 32'(pos), 321);
        exp_q.push_back(10'd321);
        step(3);
        count = 8'hFE;
        step(1);
        chk("wrap_down_pos", 32'(pos), 320);
        exp_q.push_back(10'd320);
        step(3);

        // Saturation at both edges under backpressure
        do_reset(8'h00, 1'b0);
        count = count + 8'd127;
        step(1);
        chk("sat_first_pos", 32'(pos), 351);
        exp_q.push_back(10'd351);
        for (int i = 0; i < 11; i++) begin
            count = count + 8'd127;
            step(1);
        end
        chk("sat_max_pos", 32'(pos), 639);
        chk("sat_at_max", 32'(at_max), 1);
        count = count - 8'd4;
        step(1);
        chk("sat_max_release", 32'(pos), 638);
        chk("sat_at_max_clr", 32'(at_max), 0);
        for (int i = 0; i < 24; i++) begin
            count = count - 8'd127;
            step(1);
        end
        chk("sat_min_pos", 32'(pos), 0);
        chk("sat_at_min", 32'(at_min), 1);
        count = count + 8'd4;
        step(1);
        chk("sat_min_release", 32'(pos), 1);
        chk("sat_at_min_clr", 32'(at_min), 0);
        chk("sat_pending_pos", 32'(move_pos), 351);
        exp_q.push_back(10'd1);
        move_ready = 1'b1;
        step(4);

        // Backpressure coalescing: 322 must never be sent
        do_reset(8'h00, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            count = 8'(4 * i);
            step(1);
            if (i == 1) exp_q.push_back(10'd321);
        end
        chk("coal_pos", 32'(pos), 323);
        step(2);
        chk("coal_valid_held", 32'(move_valid), 1);
        chk("coal_pos_held", 32'(move_pos), 321);
        exp_q.push_back(10'd323);
        move_ready = 1'b1;
        step(1);
        move_ready = 1'b0;
        step(3);
        chk("coal_next_valid", 32'(move_valid), 1);
        move_ready = 1'b1;
        step(3);

        // Clear while a request is pending, with a simultaneous +4
        do_reset(8'h00, 1'b0);
        count = 8'h04;
        step(1);
        exp_q.push_back(10'd321);
        step(1);
        clear = 1'b1;
        count = 8'h08;
        step(1);
        clear = 1'b0;
        chk("clear_pos", 32'(pos), 320);
        step(2);
        chk("clear_pend_valid", 32'(move_valid), 1);
        chk("clear_pend_pos", 32'(move_pos), 321);
        chk("clear_pos_stable", 32'(pos), 320);
        exp_q.push_back(10'd320);
        move_ready = 1'b1;
        step(5);
        chk("final_idle", 32'(move_valid), 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
